// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter giving two requesters shared access to one single-port RAM port.
// Latency: grant and RAM drive are combinational; read data and rvalid arrive 1 cycle after the grant.
// Backpressure: a requester that loses arbitration holds its request until gntN; nothing is queued inside.
module sp_ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] di;
    } ram_cmd_t;

    logic     prio;
    logic     rv0;
    logic     rv1;
    ram_cmd_t cmd0;
    ram_cmd_t cmd1;
    ram_cmd_t cmd_sel;

    assign cmd0 = {we0, addr0, wdata0};
    assign cmd1 = {we1, addr1, wdata1};

    // Grants are masked during reset so nothing reaches the RAM while rst is high.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || !prio)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        cmd_sel = '0;
        if (gnt0) begin
            cmd_sel = cmd0;
        end else if (gnt1) begin
            cmd_sel = cmd1;
        end
    end

    assign ram_en   = gnt0 | gnt1;
    assign ram_we   = cmd_sel.we;
    assign ram_addr = cmd_sel.addr;
    assign ram_di   = cmd_sel.di;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
            rv0  <= 1'b0;
            rv1  <= 1'b0;
        end else begin
            if (gnt0) begin
                prio <= 1'b1;
            end else if (gnt1) begin
                prio <= 1'b0;
            end
            rv0 <= gnt0 & ~we0;
            rv1 <= gnt1 & ~we1;
        end
    end

    // The RAM output register already carries the returned word; no local capture needed.
    assign rvalid0 = rv0;
    assign rvalid1 = rv1;
    assign rdata   = ram_dout;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed scenarios plus randomized traffic against a
// behavioural model (shadow memory, turn tracker, expected read return).
module tb_sp_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic        ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] ram_di;
    logic [15:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    sp_ram_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_di(ram_di), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // No-change single-port RAM with registered read.
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            else        ram_dout <= mem[ram_addr];
        end
    end

    // Reference model: whose turn it is under contention, expected read returns, shadow memory.
    bit          m_turn1;
    bit          m_rv0, m_rv1;
    logic [15:0] m_rdata;
    logic [15:0] shadow [0:1023];

    function automatic logic [1:0] exp_gnt();
        if (rst) return 2'b00;
        if (req0 && req1) return m_turn1 ? 2'b10 : 2'b01;
        return {req1, req0};
    endfunction

    task automatic model_reset();
        m_turn1 = 1'b0;
        m_rv0   = 1'b0;
        m_rv1   = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0] g;
        g = exp_gnt();
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        if (g[0]) begin
            if (we0) shadow[addr0] = wdata0;
            else begin m_rdata = shadow[addr0]; m_rv0 = 1'b1; end
            m_turn1 = 1'b1;
        end else if (g[1]) begin
            if (we1) shadow[addr1] = wdata1;
            else begin m_rdata = shadow[addr1]; m_rv1 = 1'b1; end
            m_turn1 = 1'b0;
        end
        if (rst) model_reset();
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [9:0] a1, input logic [15:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic next_cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 0, 10'h005, 16'h0, 0, 0, 10'h0, 16'h0);
        #2;
        n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0: got %b want 0", gnt0); end
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
        n_checks++; if ({rvalid1, rvalid0} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {rvalid1, rvalid0}); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        // read granted to 0, leaving the turn with 1
        @(negedge clk);
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rstA_gnt0: got %b want 1", gnt0); end
        next_cycle();
        drive(1, 0, 10'h006, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL rstB_rvalid0: got %b want 1", rvalid0); end
        rst = 1'b1;
        #1;
        n_checks++; if ({gnt1, gnt0} !== 2'b00) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 00", {gnt1, gnt0}); end
        n_checks++; if ({ram_en, ram_we} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ram: got en/we %b want 00", {ram_en, ram_we}); end
        n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid0: got %b want 0", rvalid0); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 0, 10'h001, 16'h0, 1, 0, 10'h002, 16'h0);
        @(negedge clk);
        n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL rst_first_contended: got %b want 01", {gnt1, gnt0}); end
        next_cycle();
        drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if ({rvalid1, rvalid0} !== 2'b01) begin n_fail++; $display("FAIL rst_contended_rv: got %b want 01", {rvalid1, rvalid0}); end
        next_cycle();
    endtask

    task automatic test_write_read();
        drive(1, 1, 10'h155, 16'hBEEF, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if ({gnt0, ram_en, ram_we} !== 3'b111) begin n_fail++; $display("FAIL wr_ctrl: got gnt0/en/we %b want 111", {gnt0, ram_en, ram_we}); end
        n_checks++; if (ram_addr !== 10'h155 || ram_di !== 16'hBEEF) begin n_fail++; $display("FAIL wr_bus: got %h/%h want 155/beef", ram_addr, ram_di); end
        next_cycle();
        drive(1, 0, 10'h155, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if ({ram_en, ram_we} !== 2'b10) begin n_fail++; $display("FAIL rd_ctrl: got en/we %b want 10", {ram_en, ram_we}); end
        next_cycle();
        drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if ({rvalid1, rvalid0} !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid: got %b want 01", {rvalid1, rvalid0}); end
        n_checks++; if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", rdata); end
        next_cycle();
    endtask

    task automatic test_contention();
        drive(1, 1, 10'h010, 16'h1111, 0, 0, 10'h0, 16'h0);
        next_cycle();
        drive(0, 0, 10'h0, 16'h0, 1, 1, 10'h020, 16'h2222);
        next_cycle();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1, 0, 10'h010, 16'h0, 1, 0, 10'h020, 16'h0);
            else       drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
            @(negedge clk);
            if (i < 8) begin
                n_checks++;
                if ({gnt1, gnt0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            if (i > 0) begin
                n_checks++;
                if ({rvalid1, rvalid0} !== (((i - 1) % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL cont_rv[%0d]: got %b", i, {rvalid1, rvalid0});
                end
                n_checks++;
                if (rdata !== (((i - 1) % 2 == 0) ? 16'h1111 : 16'h2222)) begin
                    n_fail++; $display("FAIL cont_rdata[%0d]: got %h", i, rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_mixed();
        drive(1, 1, 10'h3FF, 16'h00AA, 1, 0, 10'h3FF, 16'h0);
        @(negedge clk);
        n_checks++; if ({gnt1, gnt0, ram_we} !== 3'b011) begin n_fail++; $display("FAIL mix_wr: got gnt1/gnt0/we %b want 011", {gnt1, gnt0, ram_we}); end
        next_cycle();
        drive(0, 0, 10'h0, 16'h0, 1, 0, 10'h3FF, 16'h0);
        @(negedge clk);
        n_checks++; if ({gnt1, gnt0, ram_we} !== 3'b100) begin n_fail++; $display("FAIL mix_rd: got gnt1/gnt0/we %b want 100", {gnt1, gnt0, ram_we}); end
        next_cycle();
        drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if ({rvalid1, rvalid0} !== 2'b10 || rdata !== 16'h00AA) begin
            n_fail++; $display("FAIL mix_ret: got rv %b data %h want 10/00aa", {rvalid1, rvalid0}, rdata);
        end
        next_cycle();
    endtask

    task automatic test_idle_hold();
        drive(0, 0, 10'h0, 16'h0, 1, 0, 10'h020, 16'h0);
        @(negedge clk);
        n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL idle_gnt1: got %b want 1", gnt1); end
        next_cycle();
        drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL idle_en[%0d]: got %b want 0", c, ram_en); end
            n_checks++; if (rvalid1 !== (c == 1)) begin n_fail++; $display("FAIL idle_rv1[%0d]: got %b want %b", c, rvalid1, c == 1); end
            n_checks++; if (rdata !== 16'h2222) begin n_fail++; $display("FAIL idle_rdata[%0d]: got %h want 2222", c, rdata); end
            next_cycle();
        end
        drive(1, 0, 10'h010, 16'h0, 1, 0, 10'h020, 16'h0);
        @(negedge clk);
        n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL idle_prio: got %b want 01", {gnt1, gnt0}); end
        next_cycle();
        drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
        next_cycle();
    endtask

    task automatic test_reset_outstanding();
        drive(1, 0, 10'h155, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL ro_gnt0: got %b want 1", gnt0); end
        next_cycle();
        rst = 1'b1;
        drive(0, 0, 10'h0, 16'h0, 1, 1, 10'h155, 16'h5555);
        model_reset();
        @(negedge clk);
        n_checks++; if ({rvalid1, rvalid0} !== 2'b00) begin n_fail++; $display("FAIL ro_rvalid: got %b want 00", {rvalid1, rvalid0}); end
        n_checks++; if ({gnt1, ram_en, ram_we} !== 3'b000) begin n_fail++; $display("FAIL ro_ram: got gnt1/en/we %b want 000", {gnt1, ram_en, ram_we}); end
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if ({rvalid1, rvalid0} !== 2'b00) begin n_fail++; $display("FAIL ro_rvalid_after: got %b want 00", {rvalid1, rvalid0}); end
        next_cycle();
        drive(1, 0, 10'h155, 16'h0, 0, 0, 10'h0, 16'h0);
        next_cycle();
        drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        n_checks++; if (rvalid0 !== 1'b1 || rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL ro_no_write: got rv0 %b data %h want 1/beef", rvalid0, rdata);
        end
        next_cycle();
    endtask

    task automatic test_random();
        bit         p0, p1;
        logic [1:0] g;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0) begin
                req0 = ($urandom_range(0, 9) < 7); we0 = 1'($urandom_range(0, 1));
                addr0 = 10'($urandom_range(0, 7)); wdata0 = 16'($urandom);
            end
            if (!p1) begin
                req1 = ($urandom_range(0, 9) < 7); we1 = 1'($urandom_range(0, 1));
                addr1 = 10'($urandom_range(0, 7)); wdata1 = 16'($urandom);
            end
            @(negedge clk);
            g = exp_gnt();
            n_checks++; if ({gnt1, gnt0} !== g) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", i, {gnt1, gnt0}, g); end
            n_checks++;
            if (g[0] && {ram_en, ram_we, ram_addr, ram_di} !== {1'b1, we0, addr0, wdata0}) begin
                n_fail++; $display("FAIL rnd_ram0[%0d]: got en %b we %b a %h d %h", i, ram_en, ram_we, ram_addr, ram_di);
            end else if (g[1] && {ram_en, ram_we, ram_addr, ram_di} !== {1'b1, we1, addr1, wdata1}) begin
                n_fail++; $display("FAIL rnd_ram1[%0d]: got en %b we %b a %h d %h", i, ram_en, ram_we, ram_addr, ram_di);
            end else if (g == 2'b00 && {ram_en, ram_we, ram_addr, ram_di} !== 28'h0) begin
                n_fail++; $display("FAIL rnd_ram_idle[%0d]: got en %b we %b a %h d %h", i, ram_en, ram_we, ram_addr, ram_di);
            end
            n_checks++;
            if ({rvalid1, rvalid0} !== {m_rv1, m_rv0}) begin
                n_fail++; $display("FAIL rnd_rv[%0d]: got %b want %b", i, {rvalid1, rvalid0}, {m_rv1, m_rv0});
            end
            if (m_rv0 || m_rv1) begin
                n_checks++;
                if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rdata, m_rdata); end
            end
            p0 = req0 && !g[0];
            p1 = req1 && !g[1];
            next_cycle();
        end
        drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
        next_cycle();
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin
            mem[k]    = 16'h0;
            shadow[k] = 16'h0;
        end
        ram_dout = 16'h0;
        m_rdata  = 16'h0;
        model_reset();
        test_reset();
        test_write_read();
        test_contention();
        test_mixed();
        test_idle_hold();
        test_reset_outstanding();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
